regs_file_mp: RTL

- Parametrised multi-port integer register file for the pipelined core.
- Successor to the single-cycle 2R/1W register file. Adds configurable read/write port counts, configurable depth and width, deterministic write-port priority, and an integrated busy-bit scoreboard for hazard detection.
- Sits between decode (reads, issue marking) and writeback (writes, busy clearing).

---
 rtl/regs_pkg.sv | 12 +
 rtl/regs_scoreboard.sv | 72 +++++++
 rtl/regs_file_mp.sv | 129 ++++++++++++
 3 files changed

// File: rtl/regs_pkg.sv
// Shared definitions for the multi-port register file: default geometry and
// the register-index / register-data types used by the core around it.
package regs_pkg;

    localparam int REG_NUM_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF    = 32;
    localparam int NUM_REGS_DEF      = 32;

    typedef logic [REG_NUM_WIDTH_DEF-1:0] reg_num_t;
    typedef logic [DATA_WIDTH_DEF-1:0]    reg_data_t;

endpackage : regs_pkg

// File: rtl/regs_scoreboard.sv
// Busy-bit scoreboard for the register file. Decode marks a destination busy
// on issue; any enabled writeback port clears it. A same-cycle issue wins over
// a clear because the newly issued producer supersedes the completing one.
// Register 0 is never busy. busy_count_o tracks the population of busy_vec_o.
module regs_scoreboard
    import regs_pkg::*;
#(
    parameter int NUM_REGS      = NUM_REGS_DEF,
    parameter int REG_NUM_WIDTH = REG_NUM_WIDTH_DEF,
    parameter int WRITE_PORTS   = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               issue_en_i,
    input  logic [REG_NUM_WIDTH-1:0]           issue_num_i,
    input  logic [WRITE_PORTS-1:0]             wr_en_i,
    input  logic [WRITE_PORTS*REG_NUM_WIDTH-1:0] wr_num_i,
    output logic [NUM_REGS-1:0]                busy_vec_o,
    output logic [REG_NUM_WIDTH:0]             busy_count_o
);

    logic [NUM_REGS-1:0]    busy_q;
    logic [NUM_REGS-1:0]    busy_d;
    logic [NUM_REGS-1:0]    set_vec;
    logic [NUM_REGS-1:0]    clr_vec;
    logic [REG_NUM_WIDTH:0] count_q;
    logic [REG_NUM_WIDTH:0] count_d;

    // Next busy state from issue (set) and writeback (clear), plus its popcount.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update so
        // no path leaves it unassigned and no latch is inferred.
        set_vec = '0;
        clr_vec = '0;
        count_d = '0;

        if (issue_en_i) begin
            set_vec[issue_num_i] = 1'b1;
        end

        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (wr_en_i[w]) begin
                clr_vec[wr_num_i[w*REG_NUM_WIDTH +: REG_NUM_WIDTH]] = 1'b1;
            end
        end

        // Set dominates clear; x0 is forced idle so issues/writes to it vanish.
        busy_d    = set_vec | (busy_q & ~clr_vec);
        busy_d[0] = 1'b0;

        for (int r = 0; r < NUM_REGS; r++) begin
            count_d = count_d + {{REG_NUM_WIDTH{1'b0}}, busy_d[r]};
        end
    end

    // Busy bits and their count update together so they never disagree.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is assigned with <= so every flop samples the
        // pre-edge values, independent of statement order.
        if (reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_vec_o   = busy_q;
    assign busy_count_o = count_q;

endmodule : regs_scoreboard

// File: rtl/regs_file_mp.sv
// Parametrised multi-port integer register file with busy-bit scoreboard.
// Writes land on the rising edge; on a same-register collision the
// highest-numbered write port wins. Reads are combinational. Register 0 reads
// 0, is never busy, and ignores writes and issues.
// Build option: define REGS_BYPASS_EN to forward same-cycle write data to
// matching read ports (and report such registers as not busy unless they are
// being re-issued in that same cycle).
module regs_file_mp
    import regs_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int NUM_REGS      = NUM_REGS_DEF,
    parameter int REG_NUM_WIDTH = REG_NUM_WIDTH_DEF,
    parameter int READ_PORTS    = 2,
    parameter int WRITE_PORTS   = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [READ_PORTS*REG_NUM_WIDTH-1:0]  rd_num,
    output logic [READ_PORTS*DATA_WIDTH-1:0]     rd_data,
    output logic [READ_PORTS-1:0]                rd_busy,
    input  logic [WRITE_PORTS-1:0]               wr_en,
    input  logic [WRITE_PORTS*REG_NUM_WIDTH-1:0] wr_num,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0]    wr_data,
    input  logic                                 issue_en,
    input  logic [REG_NUM_WIDTH-1:0]             issue_num,
    output logic [NUM_REGS-1:0]                  busy_vec,
    output logic [REG_NUM_WIDTH:0]               busy_count
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    regs_scoreboard #(
        .NUM_REGS      (NUM_REGS),
        .REG_NUM_WIDTH (REG_NUM_WIDTH),
        .WRITE_PORTS   (WRITE_PORTS)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .issue_en_i   (issue_en),
        .issue_num_i  (issue_num),
        .wr_en_i      (wr_en),
        .wr_num_i     (wr_num),
        .busy_vec_o   (busy_vec),
        .busy_count_o (busy_count)
    );

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------

    // Merge all write ports into the next array image; x0 is never targeted.
    always_comb begin
        regs_d = regs_q;
        // NOTE: ports are visited in ascending order, so when several target
        // the same register the last (highest-numbered) assignment wins.
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (wr_en[w] && (wr_num[w*REG_NUM_WIDTH +: REG_NUM_WIDTH] != '0)) begin
                regs_d[wr_num[w*REG_NUM_WIDTH +: REG_NUM_WIDTH]] =
                    wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Register array; reset clears every entry, dropping any in-flight write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: this array is built from flops, not RAM, and the register
            // file must come out of reset all-zero, so each entry is reset.
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------

    // Per-port read mux, optional forwarding, and x0 / reset masking.
    always_comb begin
        logic [REG_NUM_WIDTH-1:0] idx;
        logic [DATA_WIDTH-1:0]    data;
        logic                     busy;
`ifdef REGS_BYPASS_EN
        logic                     fwd_hit;
`endif

        rd_data = '0;
        rd_busy = '0;

        for (int p = 0; p < READ_PORTS; p++) begin
            idx  = rd_num[p*REG_NUM_WIDTH +: REG_NUM_WIDTH];
            data = regs_q[idx];
            busy = busy_vec[idx];

`ifdef REGS_BYPASS_EN
            // Highest-numbered matching write port supplies the data. A
            // forwarded register only stays busy if it is re-issued now.
            fwd_hit = 1'b0;
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (wr_en[w] && (wr_num[w*REG_NUM_WIDTH +: REG_NUM_WIDTH] == idx)) begin
                    data    = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                    fwd_hit = 1'b1;
                end
            end
            if (fwd_hit && !(issue_en && (issue_num == idx))) begin
                busy = 1'b0;
            end
`endif

            // x0 is hard-wired to zero; during reset all reads are zero too.
            if (reset || (idx == '0)) begin
                data = '0;
                busy = 1'b0;
            end

            rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
            rd_busy[p]                          = busy;
        end
    end

endmodule : regs_file_mp
